// File: rtl/rv32_instr_encoder.sv
// Packs decoded RV32IM fields into a machine word and writes it to instruction memory at an auto-incrementing address.
// Latency: accept at edge N, imem_wr_en sampled high at edge N+2; 3 cycles/word minimum. Stalls in WRITE until imem_ack.
// Optional macro RV32_ENC_RANGE_CHECK_EN rejects immediates that do not fit their field instead of truncating them.
module rv32_instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        op_class,
    input  logic [2:0]        funct3,
    input  logic              alt,
    input  logic              m_ext,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cls_q, cls_d;
    logic [2:0]        f3_q, f3_d;
    logic              alt_q, alt_d;
    logic              m_q, m_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [31:0]       imm_q, imm_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [31:0] word_c;
    logic        legal_c;
    logic        is_shift;
    logic [6:0]  f7;

    // Encoder datapath: operates only on the latched bundle.
    always_comb begin
        word_c   = '0;
        is_shift = (cls_q == 4'd1) && (f3_q == 3'b001 || f3_q == 3'b101);
        f7       = m_q ? 7'b0000001 : (alt_q ? 7'b0100000 : 7'b0000000);
        case (cls_q)
            4'd0: word_c = {f7, rs2_q, rs1_q, f3_q, rd_q, OPC_R};
            4'd1: begin
                if (is_shift)
                    word_c = {f7, imm_q[4:0], rs1_q, f3_q, rd_q, OPC_IMM};
                else
                    word_c = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_IMM};
            end
            4'd2: word_c = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_LOAD};
            4'd3: word_c = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OPC_STORE};
            4'd4: word_c = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                            imm_q[4:1], imm_q[11], OPC_BRANCH};
            4'd5: word_c = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OPC_JAL};
            4'd6: word_c = {imm_q[11:0], rs1_q, 3'b000, rd_q, OPC_JALR};
            4'd7: word_c = {imm_q[31:12], rd_q, OPC_LUI};
            4'd8: word_c = {imm_q[31:12], rd_q, OPC_AUIPC};
            default: word_c = '0;
        endcase
    end

    always_comb begin
        legal_c = 1'b1;
        if (cls_q > 4'd8)
            legal_c = 1'b0;
        if (m_q && (cls_q != 4'd0 || alt_q))
            legal_c = 1'b0;
        if (alt_q && !((cls_q == 4'd0 && (f3_q == 3'b000 || f3_q == 3'b101)) ||
                       (cls_q == 4'd1 && f3_q == 3'b101)))
            legal_c = 1'b0;
        if (cls_q == 4'd2 && (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111))
            legal_c = 1'b0;
        if (cls_q == 4'd3 && f3_q > 3'b010)
            legal_c = 1'b0;
        if (cls_q == 4'd4 && (f3_q == 3'b010 || f3_q == 3'b011))
            legal_c = 1'b0;
`ifdef RV32_ENC_RANGE_CHECK_EN
        case (cls_q)
            4'd1, 4'd2, 4'd3, 4'd6: begin
                if (is_shift) begin
                    if (imm_q > 32'd31)
                        legal_c = 1'b0;
                end else if ($signed(imm_q) < -2048 || $signed(imm_q) > 2047) begin
                    legal_c = 1'b0;
                end
            end
            4'd4: if ($signed(imm_q) < -4096 || $signed(imm_q) > 4094 || imm_q[0])
                legal_c = 1'b0;
            4'd5: if ($signed(imm_q) < -1048576 || $signed(imm_q) > 1048574 || imm_q[0])
                legal_c = 1'b0;
            4'd7, 4'd8: if (imm_q[11:0] != 12'd0)
                legal_c = 1'b0;
            default: ;
        endcase
`endif
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        f3_d    = f3_q;
        alt_d   = alt_q;
        m_d     = m_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        wr_en_d = wr_en_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A coincident load retargets the bundle accepted in the same cycle.
                if (addr_load)
                    ptr_d = load_addr & ~ADDR_W'(3);
                if (req_valid) begin
                    cls_d   = op_class;
                    f3_d    = funct3;
                    alt_d   = alt;
                    m_d     = m_ext;
                    rd_d    = rd;
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    imm_d   = imm;
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                if (legal_c) begin
                    wdata_d = word_c;
                    wr_en_d = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (imem_ack) begin
                    wr_en_d = 1'b0;
                    ptr_d   = ptr_q + ADDR_W'(4);
                    if (cnt_q != 16'hFFFF)
                        cnt_d = cnt_q + 16'd1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cls_q   <= '0;
            f3_q    <= '0;
            alt_q   <= 1'b0;
            m_q     <= 1'b0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            wr_en_q <= 1'b0;
            ptr_q   <= BASE;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            f3_q    <= f3_d;
            alt_q   <= alt_d;
            m_q     <= m_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            wr_en_q <= wr_en_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign imem_wr_en = wr_en_q;
    assign imem_addr  = ptr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Randomized and directed bench for rv32_instr_encoder against a field-placement reference model.
module tb_rv32_instr_encoder;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        op_class;
    logic [2:0]        funct3;
    logic              alt;
    logic              m_ext;
    logic [4:0]        rd, rs1, rs2;
    logic [31:0]       imm;
    logic              addr_load;
    logic [ADDR_W-1:0] load_addr;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ack;
    logic              done;
    logic              err;
    logic [15:0]       word_count;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] exp_ptr;
    int                exp_cnt;

    bit                obs_tmo, obs_err, obs_err2, obs_wr, obs_stable, obs_done, obs_wr_after, obs_rdy_wr;
    logic [ADDR_W-1:0] obs_addr;
    logic [31:0]       obs_data;

    rv32_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .op_class(op_class), .funct3(funct3), .alt(alt), .m_ext(m_ext),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .addr_load(addr_load), .load_addr(load_addr),
        .imem_wr_en(imem_wr_en), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ack(imem_ack), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    function automatic bit model_legal(input int c, input int f, input bit a, input bit m,
                                       input logic [31:0] im);
        bit ok;
        int si;
        ok = 1'b1;
        si = $signed(im);
        if (c > 8) ok = 1'b0;
        if (m && (c != 0 || a)) ok = 1'b0;
        if (a && !((c == 0 && (f == 0 || f == 5)) || (c == 1 && f == 5))) ok = 1'b0;
        if (c == 2 && (f == 3 || f >= 6)) ok = 1'b0;
        if (c == 3 && f > 2) ok = 1'b0;
        if (c == 4 && (f == 2 || f == 3)) ok = 1'b0;
`ifdef RV32_ENC_RANGE_CHECK_EN
        if (c == 1 && (f == 1 || f == 5)) begin
            if (si < 0 || si > 31) ok = 1'b0;
        end else if (c == 1 || c == 2 || c == 3 || c == 6) begin
            if (si < -2048 || si > 2047) ok = 1'b0;
        end
        if (c == 4 && (si < -4096 || si > 4094 || im[0])) ok = 1'b0;
        if (c == 5 && (si < -1048576 || si > 1048574 || im[0])) ok = 1'b0;
        if ((c == 7 || c == 8) && (im % 4096) != 0) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [31:0] model_word(input int unsigned c, input int unsigned f,
                                               input bit a, input bit m, input int unsigned d,
                                               input int unsigned s1, input int unsigned s2,
                                               input logic [31:0] im);
        int unsigned u, w, hi;
        u  = im;
        hi = m ? 1 : (a ? 32 : 0);
        case (c)
            0: w = 'h33 | d << 7 | f << 12 | s1 << 15 | s2 << 20 | hi << 25;
            1: if (f == 1 || f == 5)
                   w = 'h13 | d << 7 | f << 12 | s1 << 15 | (u & 31) << 20 | hi << 25;
               else
                   w = 'h13 | d << 7 | f << 12 | s1 << 15 | (u & 'hFFF) << 20;
            2: w = 'h03 | d << 7 | f << 12 | s1 << 15 | (u & 'hFFF) << 20;
            3: w = 'h23 | (u & 31) << 7 | f << 12 | s1 << 15 | s2 << 20 | ((u >> 5) & 127) << 25;
            4: w = 'h63 | ((u >> 11) & 1) << 7 | ((u >> 1) & 15) << 8 | f << 12 | s1 << 15
                   | s2 << 20 | ((u >> 5) & 63) << 25 | ((u >> 12) & 1) << 31;
            5: w = 'h6F | d << 7 | ((u >> 12) & 255) << 12 | ((u >> 11) & 1) << 20
                   | ((u >> 1) & 1023) << 21 | ((u >> 20) & 1) << 31;
            6: w = 'h67 | d << 7 | s1 << 15 | (u & 'hFFF) << 20;
            7: w = 'h37 | d << 7 | (u & 'hFFFFF000);
            8: w = 'h17 | d << 7 | (u & 'hFFFFF000);
            default: w = 0;
        endcase
        return w;
    endfunction

    // Drives one bundle and records what the DUT did with it in the obs_* variables.
    task automatic send(input logic [3:0] c, input logic [2:0] f, input bit a, input bit m,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im, input int ack_dly, input bit ld,
                        input logic [ADDR_W-1:0] la);
        int n;
        obs_err = 0; obs_err2 = 0; obs_wr = 0; obs_stable = 0; obs_done = 0;
        obs_wr_after = 0; obs_rdy_wr = 0; obs_addr = '0; obs_data = '0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        obs_tmo = !req_ready;
        op_class = c; funct3 = f; alt = a; m_ext = m; rd = d; rs1 = s1; rs2 = s2; imm = im;
        addr_load = ld; load_addr = la; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; addr_load = 1'b0;
        @(posedge clk); #1;
        obs_err = err; obs_wr = imem_wr_en; obs_addr = imem_addr; obs_data = imem_wdata;
        obs_rdy_wr = req_ready;
        if (imem_wr_en) begin
            obs_stable = 1;
            for (int i = 0; i < ack_dly; i++) begin
                @(posedge clk); #1;
                if (!imem_wr_en || imem_addr !== obs_addr || imem_wdata !== obs_data || req_ready)
                    obs_stable = 0;
            end
            imem_ack = 1'b1;
            @(posedge clk); #1;
            imem_ack = 1'b0;
            obs_done = done; obs_wr_after = imem_wr_en;
        end else begin
            @(posedge clk); #1;
            obs_err2 = err; obs_done = done; obs_wr_after = imem_wr_en;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 0; op_class = 0; funct3 = 0; alt = 0; m_ext = 0;
        rd = 0; rs1 = 0; rs2 = 0; imm = 0; addr_load = 0; load_addr = 0; imem_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (imem_wr_en !== 1'b0 || done !== 1'b0 || err !== 1'b0 || imem_wdata !== 32'h0 ||
            word_count !== 16'h0 || imem_addr !== 10'h000) begin
            failures++;
            $display("FAIL reset_state: wr_en=%b done=%b err=%b wdata=%h cnt=%0d addr=%h, required all zero",
                     imem_wr_en, done, err, imem_wdata, word_count, imem_addr);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
        end
        exp_ptr = '0;
        exp_cnt = 0;
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [2:0]  f;
        bit          m;
        logic [4:0]  d, s1, s2;
        logic [31:0] im;
        logic [31:0] w;
    } vec_t;

    task automatic test_known_words();
        vec_t tv[5];
        tv[0] = '{4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,  32'h002081B3};
        tv[1] = '{4'd0, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0,  32'h023100B3};
        tv[2] = '{4'd1, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, -32'sd1, 32'hFFF00293};
        tv[3] = '{4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,  32'h0020A423};
        tv[4] = '{4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE208EE3};
        for (int i = 0; i < 5; i++) begin
            send(tv[i].c, tv[i].f, 1'b0, tv[i].m, tv[i].d, tv[i].s1, tv[i].s2, tv[i].im, 0, 1'b0, '0);
            checks++;
            if (obs_tmo || !obs_wr || obs_addr !== exp_ptr || obs_data !== tv[i].w ||
                !obs_done || obs_wr_after) begin
                failures++;
                $display("FAIL known_word[%0d]: wr=%b addr=%h data=%h done=%b, required addr=%h data=%h done=1",
                         i, obs_wr, obs_addr, obs_data, obs_done, exp_ptr, tv[i].w);
            end
            exp_ptr += 10'd4;
            exp_cnt++;
            if (i == 1) begin
                checks++;
                if (word_count !== 16'd2) begin
                    failures++;
                    $display("FAIL count_after_two: word_count=%0d required 2", word_count);
                end
            end
        end
    endtask

    task automatic test_imm_2048();
        send(4'd1, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd2048, 0, 1'b0, '0);
`ifdef RV32_ENC_RANGE_CHECK_EN
        checks++;
        if (!obs_err || obs_wr || obs_err2 || imem_addr !== exp_ptr || word_count !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL addi_2048_reject: err=%b wr=%b addr=%h cnt=%0d, required err=1 wr=0 addr=%h cnt=%0d",
                     obs_err, obs_wr, imem_addr, word_count, exp_ptr, exp_cnt);
        end
`else
        checks++;
        if (!obs_wr || obs_err || obs_data !== 32'h80000013 || obs_addr !== exp_ptr) begin
            failures++;
            $display("FAIL addi_2048_trunc: wr=%b err=%b data=%h addr=%h, required wr=1 data=80000013 addr=%h",
                     obs_wr, obs_err, obs_data, obs_addr, exp_ptr);
        end
        exp_ptr += 10'd4;
        exp_cnt++;
`endif
    endtask

    task automatic test_backpressure();
        send(4'd0, 3'b101, 1'b1, 1'b0, 5'd7, 5'd8, 5'd9, 32'd0, 5, 1'b0, '0);
        checks++;
        if (!obs_wr || obs_rdy_wr || !obs_stable || !obs_done || obs_wr_after ||
            obs_data !== model_word(0, 5, 1, 0, 7, 8, 9, 0) || obs_addr !== exp_ptr) begin
            failures++;
            $display("FAIL ack_hold: wr=%b ready=%b stable=%b done=%b wr_after=%b data=%h, required 1 0 1 1 0 %h",
                     obs_wr, obs_rdy_wr, obs_stable, obs_done, obs_wr_after, obs_data,
                     model_word(0, 5, 1, 0, 7, 8, 9, 0));
        end
        exp_ptr += 10'd4;
        exp_cnt++;
    endtask

    task automatic test_reset_mid_write();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        op_class = 4'd0; funct3 = 3'b000; alt = 0; m_ext = 0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (imem_wr_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_write_setup: imem_wr_en=%b required 1", imem_wr_en);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (imem_wr_en !== 1'b0 || imem_addr !== 10'h000 || word_count !== 16'h0) begin
            failures++;
            $display("FAIL mid_write_reset: wr_en=%b addr=%h cnt=%0d, required 0 000 0",
                     imem_wr_en, imem_addr, word_count);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_ptr = '0;
        exp_cnt = 0;
        send(4'd7, 3'b000, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h12345000, 1, 1'b0, '0);
        checks++;
        if (!obs_wr || obs_addr !== 10'h000 || obs_data !== 32'h12345237) begin
            failures++;
            $display("FAIL after_reset_write: wr=%b addr=%h data=%h, required 1 000 12345237",
                     obs_wr, obs_addr, obs_data);
        end
        exp_ptr += 10'd4;
        exp_cnt++;
    endtask

    task automatic test_wrap_and_load();
        @(posedge clk); #1;
        addr_load = 1'b1; load_addr = 10'h3FF;
        @(posedge clk); #1;
        addr_load = 1'b0;
        checks++;
        if (imem_addr !== 10'h3FC) begin
            failures++;
            $display("FAIL addr_load: imem_addr=%h required 3fc", imem_addr);
        end
        exp_ptr = 10'h3FC;
        for (int i = 0; i < 2; i++) begin
            send(4'd6, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd16, 0, 1'b0, '0);
            checks++;
            if (!obs_wr || obs_addr !== exp_ptr || obs_data !== 32'h010100E7) begin
                failures++;
                $display("FAIL wrap[%0d]: addr=%h data=%h, required addr=%h data=010100e7",
                         i, obs_addr, obs_data, exp_ptr);
            end
            exp_ptr += 10'd4;
            exp_cnt++;
        end
        send(4'd5, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 1'b1, 10'h105);
        exp_ptr = 10'h104;
        checks++;
        if (!obs_wr || obs_addr !== exp_ptr || obs_data !== model_word(5, 0, 0, 0, 1, 0, 0, 2048)) begin
            failures++;
            $display("FAIL load_with_accept: addr=%h data=%h, required addr=%h data=%h",
                     obs_addr, obs_data, exp_ptr, model_word(5, 0, 0, 0, 1, 0, 0, 2048));
        end
        exp_ptr += 10'd4;
        exp_cnt++;
        send(4'd2, 3'b011, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, 0, 1'b0, '0);
        checks++;
        if (!obs_err || obs_err2 || obs_wr || obs_wr_after || obs_done ||
            imem_addr !== exp_ptr || word_count !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL load_f3_011: err=%b err2=%b wr=%b done=%b addr=%h cnt=%0d, required err=1 pulse, no write, addr=%h cnt=%0d",
                     obs_err, obs_err2, obs_wr, obs_done, imem_addr, word_count, exp_ptr, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0]  c;
        logic [2:0]  f;
        bit          a, m, ok;
        logic [4:0]  d, s1, s2;
        logic [31:0] im, w;
        int          dly;
        for (int i = 0; i < 80; i++) begin
            c  = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            f  = 3'($urandom);
            a  = ($urandom_range(0, 3) == 0);
            m  = ($urandom_range(0, 4) == 0);
            d  = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
            case ($urandom_range(0, 2))
                0: im = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: im = 32'($urandom_range(0, 31));
                default: im = $urandom;
            endcase
            dly = $urandom_range(0, 2);
            ok  = model_legal(c, f, a, m, im);
            w   = model_word(c, f, a, m, d, s1, s2, im);
            send(c, f, a, m, d, s1, s2, im, dly, 1'b0, '0);
            checks++;
            if (ok) begin
                if (obs_tmo || !obs_wr || obs_err || obs_addr !== exp_ptr || obs_data !== w ||
                    !obs_done || obs_wr_after) begin
                    failures++;
                    $display("FAIL random[%0d] cls=%0d f3=%0d alt=%b m=%b imm=%h: wr=%b err=%b addr=%h data=%h, required write addr=%h data=%h",
                             i, c, f, a, m, im, obs_wr, obs_err, obs_addr, obs_data, exp_ptr, w);
                end
                exp_ptr += 10'd4;
                exp_cnt++;
            end else begin
                if (obs_tmo || !obs_err || obs_wr || obs_err2 || obs_done || imem_addr !== exp_ptr) begin
                    failures++;
                    $display("FAIL random_illegal[%0d] cls=%0d f3=%0d alt=%b m=%b imm=%h: err=%b wr=%b addr=%h, required err=1 wr=0 addr=%h",
                             i, c, f, a, m, im, obs_err, obs_wr, imem_addr, exp_ptr);
                end
            end
            checks++;
            if (word_count !== 16'(exp_cnt)) begin
                failures++;
                $display("FAIL random_count[%0d]: word_count=%0d required %0d", i, word_count, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_words();
        test_imm_2048();
        test_backpressure();
        test_wrap_and_load();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
